// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state encoding for the uart_tx FIFO front end
package uart_pkg;

  localparam int DEF_PAYLOAD_BITS = 8;
  localparam int DEF_DEPTH        = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO storage with push/pop/count; DEPTH must be a power of two >= 2
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DEF_PAYLOAD_BITS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Full/empty gate the requests here so the storage can never be corrupted by a caller.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO front end feeding a uart_tx start/busy handshake
// Optional sticky overflow flag enabled by macro UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [PAYLOAD_BITS-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     uart_tx_busy,
  output logic                     uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]  uart_tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  input  logic                     ovf_clr,
  output logic                     overflow
);

  tx_state_e                 r_state;
  tx_state_e                 w_next_state;
  logic                      w_pop;
  logic                      w_push;
  logic [PAYLOAD_BITS-1:0]   w_head;
  logic                      r_tx_en;
  logic [PAYLOAD_BITS-1:0]   r_tx_data;

  assign in_ready = !fifo_full;
  assign w_push   = in_valid && in_ready;

  uart_sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_push),
    .push_data (in_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // SETTLE spends one cycle ignoring busy while uart_tx raises it after the start strobe.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_empty && !uart_tx_busy) begin
          w_next_state = LAUNCH;
          w_pop        = 1'b1;
        end
      end
      LAUNCH:  w_next_state = SETTLE;
      SETTLE:  w_next_state = DRAIN;
      DRAIN: begin
        if (!uart_tx_busy) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_next_state;
      r_tx_en <= (w_next_state == LAUNCH);
      if (w_pop) begin
        r_tx_data <= w_head;
      end
    end
  end

  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;

  // A drop and a clear on the same edge leave the flag set so no drop goes unreported.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (in_valid && fifo_full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = ovf_clr;
  assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo with a queue reference model
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int PB    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [PB-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          uart_tx_busy = 1'b0;
  logic          uart_tx_en;
  logic [PB-1:0] uart_tx_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          ovf_clr = 1'b0;
  logic          overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .fifo_count   (fifo_count),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .ovf_clr      (ovf_clr),
    .overflow     (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [PB-1:0] exp_q [$];
  logic [PB-1:0] out_log [$];
  logic [PB-1:0] exp_b;
  bit            m_ovf = 0;
  bit            sv_valid = 0;
  bit            sv_full = 0;
  bit            sv_clr = 0;
  logic [PB-1:0] sv_data = '0;
  bit            prev_en = 0;
  int            en_total = 0;
  int            simul_cnt = 0;
  bit            busy_mode = 0;
  bit            busy_force = 0;
  int            busy_len = 0;
  int            bcnt = 0;

`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // Reference model: a byte queue of accepted writes; every start strobe must take its head.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      m_ovf    = 0;
      sv_valid = 0;
      sv_clr   = 0;
      sv_full  = 0;
      prev_en  = 0;
    end else begin
      if (uart_tx_en) begin
        en_total++;
        n_cmp++;
        if (prev_en) $display("FAIL en_width: en high %0d cycles, required 1", 2);
        if (prev_en) n_bad++;
        n_cmp++;
        if (uart_tx_busy !== 1'b0) begin
          n_bad++;
          $display("FAIL en_while_busy: busy=%0b at start strobe, required 0", uart_tx_busy);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL en_unexpected: strobe with data %02h, model queue empty", uart_tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          n_cmp++;
          if (uart_tx_data !== exp_b) begin
            n_bad++;
            $display("FAIL tx_data: got %02h required %02h", uart_tx_data, exp_b);
          end
        end
        out_log.push_back(uart_tx_data);
      end
      if (sv_valid && !sv_full) begin
        exp_q.push_back(sv_data);
        if (uart_tx_en) simul_cnt++;
      end
      if (OVF_ON && sv_valid && sv_full) m_ovf = 1;
      else if (OVF_ON && sv_clr) m_ovf = 0;
      n_cmp++;
      if (fifo_count !== CW'(exp_q.size())) begin
        n_bad++;
        $display("FAIL fifo_count: got %0d required %0d", fifo_count, exp_q.size());
      end
      n_cmp++;
      if (fifo_empty !== (exp_q.size() == 0) || fifo_full !== (exp_q.size() == DEPTH)) begin
        n_bad++;
        $display("FAIL flags: empty=%0b full=%0b required empty=%0b full=%0b",
                 fifo_empty, fifo_full, exp_q.size() == 0, exp_q.size() == DEPTH);
      end
      n_cmp++;
      if (overflow !== m_ovf) begin
        n_bad++;
        $display("FAIL overflow: got %0b required %0b", overflow, m_ovf);
      end
      n_cmp++;
      if (in_ready !== (exp_q.size() < DEPTH)) begin
        n_bad++;
        $display("FAIL in_ready: got %0b required %0b", in_ready, exp_q.size() < DEPTH);
      end
      prev_en  = uart_tx_en;
      sv_valid = in_valid;
      sv_data  = in_data;
      sv_clr   = ovf_clr;
      sv_full  = (exp_q.size() >= DEPTH);
    end
    if (busy_mode) begin
      if (uart_tx_en) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      uart_tx_busy = (bcnt > 0);
    end else begin
      bcnt = 0;
      uart_tx_busy = busy_force;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [PB-1:0] d);
    int guard = 0;
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    in_valid = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL push_timeout: byte %02h accepted=%0b required 1", d, acc);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || uart_tx_busy) && n < budget) begin
      tick();
      n++;
    end
    repeat (5) tick();
    n_cmp++;
    if (fifo_count !== '0 || n >= budget) begin
      n_bad++;
      $display("FAIL drain: fifo_count=%0d after %0d cycles, required 0", fifo_count, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (uart_tx_en !== 1'b0 || uart_tx_data !== '0 || fifo_count !== '0 || fifo_empty !== 1'b1 ||
        fifo_full !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: en=%0b data=%02h count=%0d empty=%0b full=%0b ovf=%0b rdy=%0b required 0 00 0 1 0 0 1",
               tag, uart_tx_en, uart_tx_data, fifo_count, fifo_empty, fifo_full, overflow, in_ready);
    end
  endtask

  task automatic test_reset();
    int e0;
    resetn = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset_state");
    resetn = 1'b1;
    e0 = en_total;
    repeat (10) tick();
    n_cmp++;
    if (en_total !== e0) begin
      n_bad++;
      $display("FAIL idle_after_reset: %0d strobes, required 0", en_total - e0);
    end
  endtask

  task automatic test_single();
    int pc;
    int ec = -1;
    busy_mode  = 0;
    busy_force = 0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    pc = cyc;
    in_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== CW'(1)) begin
      n_bad++;
      $display("FAIL single_count_after_push: got %0d required 1", fifo_count);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_tx_en === 1'b1) begin
        ec = cyc;
        break;
      end
    end
    n_cmp++;
    if (ec !== pc + 1) begin
      n_bad++;
      $display("FAIL single_latency: strobe cycle %0d required %0d", ec, pc + 1);
    end
    n_cmp++;
    if (uart_tx_data !== 8'h55 || fifo_count !== '0) begin
      n_bad++;
      $display("FAIL single_data: data=%02h count=%0d required 55 0", uart_tx_data, fifo_count);
    end
    @(negedge clk);
    n_cmp++;
    if (uart_tx_en !== 1'b0 || uart_tx_data !== 8'h55) begin
      n_bad++;
      $display("FAIL single_pulse: en=%0b data=%02h required 0 55", uart_tx_en, uart_tx_data);
    end
    tick();
    wait_drain(50);
  endtask

  task automatic test_order();
    busy_len  = 10;
    busy_mode = 1;
    out_log.delete();
    for (int i = 1; i <= 4; i++) push_byte(PB'(i));
    wait_drain(400);
    n_cmp++;
    if (out_log.size() != 4) begin
      n_bad++;
      $display("FAIL order_count: %0d bytes sent, required 4", out_log.size());
    end
    for (int i = 0; i < out_log.size() && i < 4; i++) begin
      n_cmp++;
      if (out_log[i] !== PB'(i + 1)) begin
        n_bad++;
        $display("FAIL order_byte%0d: got %02h required %02h", i, out_log[i], i + 1);
      end
    end
  endtask

  task automatic test_full();
    logic [PB-1:0] data [DEPTH];
    busy_mode  = 0;
    busy_force = 1;
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      data[i] = PB'($urandom);
      push_byte(data[i]);
    end
    n_cmp++;
    if (fifo_full !== 1'b1 || in_ready !== 1'b0 || fifo_count !== CW'(DEPTH)) begin
      n_bad++;
      $display("FAIL full_flags: full=%0b rdy=%0b count=%0d required 1 0 %0d",
               fifo_full, in_ready, fifo_count, DEPTH);
    end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== CW'(DEPTH) || overflow !== OVF_ON) begin
      n_bad++;
      $display("FAIL drop_17th: count=%0d ovf=%0b required %0d %0b", fifo_count, overflow, DEPTH, OVF_ON);
    end
    repeat (3) tick();
    n_cmp++;
    if (overflow !== OVF_ON) begin
      n_bad++;
      $display("FAIL ovf_sticky: got %0b required %0b", overflow, OVF_ON);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: got %0b required 0", overflow);
    end
    in_valid = 1'b1;
    ovf_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    n_cmp++;
    if (overflow !== OVF_ON) begin
      n_bad++;
      $display("FAIL ovf_set_wins: got %0b required %0b", overflow, OVF_ON);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    busy_len  = $urandom_range(0, 4);
    busy_mode = 1;
    out_log.delete();
    wait_drain(400);
    n_cmp++;
    if (out_log.size() != DEPTH) begin
      n_bad++;
      $display("FAIL full_drain_count: %0d bytes sent, required %0d", out_log.size(), DEPTH);
    end
    for (int i = 0; i < out_log.size() && i < DEPTH; i++) begin
      n_cmp++;
      if (out_log[i] !== data[i]) begin
        n_bad++;
        $display("FAIL full_drain_byte%0d: got %02h required %02h", i, out_log[i], data[i]);
      end
    end
  endtask

  task automatic test_wrap();
    busy_len  = $urandom_range(0, 3);
    busy_mode = 1;
    out_log.delete();
    simul_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      push_byte(PB'(i));
      repeat ($urandom_range(0, 1)) tick();
    end
    wait_drain(800);
    n_cmp++;
    if (out_log.size() != 40) begin
      n_bad++;
      $display("FAIL wrap_count: %0d bytes sent, required 40", out_log.size());
    end
    for (int i = 0; i < out_log.size() && i < 40; i++) begin
      n_cmp++;
      if (out_log[i] !== PB'(i)) begin
        n_bad++;
        $display("FAIL wrap_byte%0d: got %02h required %02h", i, out_log[i], i);
      end
    end
    n_cmp++;
    if (simul_cnt == 0) begin
      n_bad++;
      $display("FAIL wrap_concurrency: %0d simultaneous push/pop edges, required >0", simul_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    busy_len  = 10;
    busy_mode = 1;
    out_log.delete();
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    repeat (2) tick();
    n_cmp++;
    if (fifo_count !== CW'(3) || uart_tx_data !== 8'hA1) begin
      n_bad++;
      $display("FAIL mid_pre_reset: count=%0d data=%02h required 3 a1", fifo_count, uart_tx_data);
    end
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset_async");
    tick();
    tick();
    resetn = 1'b1;
    e0 = en_total;
    repeat (30) tick();
    n_cmp++;
    if (en_total !== e0 || fifo_count !== '0) begin
      n_bad++;
      $display("FAIL mid_no_en: %0d strobes count=%0d, required 0 0", en_total - e0, fifo_count);
    end
    push_byte(8'h3C);
    wait_drain(100);
    n_cmp++;
    if (en_total !== e0 + 1 || out_log.size() == 0 || out_log[out_log.size()-1] !== 8'h3C) begin
      n_bad++;
      $display("FAIL mid_new_push: %0d strobes, required 1 carrying 3c", en_total - e0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BITS, default 8, giving the width of a data word, matching the uart_tx payload width.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the FIFO entry count, which SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_data, input, width PAYLOAD_BITS: byte offered by the producer.
REQ-006 The block SHALL have port in_valid, input, width 1: producer has a byte on in_data.
REQ-007 The block SHALL have port in_ready, output, width 1: FIFO can accept a byte this cycle.
REQ-008 The block SHALL have port uart_tx_busy, input, width 1: busy flag from the downstream uart_tx.
REQ-009 The block SHALL have port uart_tx_en, output, width 1: one-cycle start strobe to uart_tx.
REQ-010 The block SHALL have port uart_tx_data, output, width PAYLOAD_BITS: byte presented to uart_tx.
REQ-011 The block SHALL have port fifo_count, output, width $clog2(DEPTH)+1: number of stored entries.
REQ-012 The block SHALL have ports fifo_empty and fifo_full, outputs, width 1 each: fifo_count==0 and fifo_count==DEPTH respectively.
REQ-013 The block SHALL have port ovf_clr, input, width 1: clears the overflow flag.
REQ-014 The block SHALL have port overflow, output, width 1: sticky flag set by a dropped write.

Function
REQ-015 in_ready SHALL equal !fifo_full combinationally; a push SHALL occur on any edge where in_valid && in_ready.
REQ-016 A push when full SHALL NOT happen; the FIFO contents and fifo_count SHALL be unchanged, and there SHALL be no write-through bypass.
REQ-017 The FSM SHALL have the states IDLE, LAUNCH, SETTLE and DRAIN.
REQ-018 From IDLE, on an edge with !fifo_empty && !uart_tx_busy, the FSM SHALL move to LAUNCH, pop the head, and register it into uart_tx_data on that same edge.
REQ-019 In LAUNCH, uart_tx_en SHALL be 1 for exactly one cycle, after which the FSM SHALL move to SETTLE unconditionally.
REQ-020 SETTLE SHALL last one cycle, with uart_tx_busy ignored, to cover the one-cycle busy rise latency of uart_tx.
REQ-021 The FSM SHALL stay in DRAIN while uart_tx_busy=1 and SHALL move to IDLE on the first edge where uart_tx_busy=0.
REQ-022 uart_tx_en SHALL be registered and SHALL be 0 in every state other than LAUNCH.
REQ-023 uart_tx_data SHALL be held stable from LAUNCH until the next pop.
REQ-024 For a push into an empty FIFO with uart_tx_busy=0, uart_tx_en SHALL be high in the cycle starting two edges after the push edge: push edge, then IDLE pop edge.
REQ-025 A simultaneous push and pop on one edge SHALL leave fifo_count unchanged and SHALL keep data order.
REQ-026 The read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH with no gap.
REQ-027 Strict FIFO order SHALL be preserved across pointer wrap-around.
REQ-028 fifo_count, fifo_empty and fifo_full SHALL be registered-derived, updating on the edge following the push or pop.

Reset
REQ-029 On resetn=0, independent of clk, the block SHALL set the FSM to IDLE, both pointers to 0, fifo_count to 0, fifo_empty to 1, fifo_full to 0, uart_tx_en to 0, uart_tx_data to 0 and overflow to 0.
REQ-030 Storage array contents SHALL NOT require reset.
REQ-031 A reset mid-operation, whether in LAUNCH, SETTLE or DRAIN, SHALL discard all queued bytes and return to IDLE.
REQ-032 After reset release, no uart_tx_en SHALL occur until a new push.

Configuration
REQ-033 With macro UART_TX_FIFO_OVF_EN defined, overflow SHALL be set on any edge with in_valid && fifo_full.
REQ-034 With UART_TX_FIFO_OVF_EN defined, ovf_clr=1 SHALL clear overflow, and a set and a clear on the same edge SHALL resolve to set.
REQ-035 With UART_TX_FIFO_OVF_EN undefined, overflow SHALL be tied to 0, ovf_clr SHALL be ignored, no flag register SHALL exist, and the ports SHALL remain present.

Structure
REQ-036 The shared package uart_pkg SHALL hold the FSM state encoding constants (IDLE=0, LAUNCH=1, SETTLE=2, DRAIN=3) and the default PAYLOAD_BITS/DEPTH constants.
REQ-037 Storage and pointers SHALL live in one sub-module, uart_sync_fifo, with push/pop/count ports.
REQ-038 The FSM and the uart_tx handshake SHALL reside in uart_tx_fifo.

Verification
REQ-039 Reset, then push 0x55 with uart_tx_busy=0 -> uart_tx_en high for exactly one cycle two edges after the push, uart_tx_data=0x55, fifo_count 1->0.
REQ-040 Push 0x01..0x04 back-to-back, with a uart_tx model holding busy for 10 cycles after each en -> four en pulses in order 0x01..0x04, each pulse only after busy has fallen.
REQ-041 Fill 16 entries while busy=1 -> fifo_full=1 and in_ready=0; a 17th push of 0xAA is dropped; with the macro defined, overflow=1 until ovf_clr; without it, overflow stays 0.
REQ-042 Run 40 bytes 0x00..0x27 through a DEPTH=16 FIFO with concurrent push/pop -> output order identical across two pointer wraps, and fifo_count unchanged on simultaneous push and pop cycles.
REQ-043 Assert resetn=0 while in DRAIN with 3 bytes queued -> outputs immediately at reset values, fifo_count=0, and no en after release until a new push.
